alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Issue stage directly upstream of the ALU. Accepts decoded-register operands plus the raw 32-bit instruction over a valid/ready handshake.
- Decodes OP (0110011) and OP-IMM (0010011), picks the register or sign-extended immediate as operand B, and synthesises funct7.
- Buffers up to two entries in a skid FIFO so the ALU-side consumer can stall without creating a combinational ready path back to fetch/decode.
- Outputs drive the ALU's iDataA, iDataB, iFunct3 and iFunct7 inputs directly.

Parameters:
- XLEN, 32, operand/data width; only 32 is supported.
- DEPTH, 2, skid-buffer entries; fixed at 2, pointer logic is one bit wide.

Ports:
- iClk  input  1  clock, all state on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iValid  input  1  upstream presents an instruction this cycle.
- oReady  output  1  stage can accept; registered, no combinational dependence on iAluReady.
- iInstr  input  32  raw instruction word.
- iRs1Data  input  32  register-file value for rs1.
- iRs2Data  input  32  register-file value for rs2.
- oValid  output  1  head entry is valid toward ALU.
- iAluReady  input  1  downstream accepts the head entry.
- oDataA  output  32  operand A (rs1 value).
- oDataB  output  32  operand B (rs2 value or immediate).
- oFunct3  output  3  instr[14:12].
- oFunct7  output  7  synthesised funct7.
- oRd  output  5  destination register, instr[11:7].
- oIllegal  output  1  one-cycle pulse when an accepted instruction is rejected.
- oCount  output  2  current occupancy (0..2).

Behaviour:
- Reset: count=0, both entries invalid, oValid=0, oReady=1, oIllegal=0, all data outputs 0. Asynchronous assertion clears the buffer immediately; an in-flight transfer in that cycle is lost.
- Accept: iValid and oReady sampled high at the edge.
- Dequeue: oValid and iAluReady sampled high at the edge.
- Decode happens at accept; entries store already-decoded fields.
- OP: B=iRs2Data; funct7=instr[31:25].
- OP-IMM: B={20{instr[31]},instr[31:20]}.
  - If funct3 is 001 or 101: funct7=instr[31:25] and B={27'b0,instr[24:20]}.
  - Otherwise funct7=0000000, so ADDI never selects SUB.
- Illegal conditions:
  - Any other opcode.
  - OP with funct7 not in {0000000, 0100000}.
  - OP with 0100000 and funct3 not in {000, 101}.
  - OP-IMM funct3=001 with instr[31:25]≠0000000.
  - OP-IMM funct3=101 with instr[31:25] not in {0000000, 0100000}.
- Illegal handling: the instruction is consumed (handshake completes) but not enqueued. oIllegal pulses high for exactly the following cycle. Count is unchanged except for any simultaneous dequeue.
- Latency: a legal instruction accepted into an empty buffer appears on oValid the next cycle (1-cycle latency).
- Ordering: strict FIFO. Outputs always reflect the head entry and must be held stable while oValid=1 and iAluReady=0.
- oReady is registered and equals (next count < 2). Consequences:
  - From count=1, a simultaneous accept and dequeue keeps count=1 and oReady=1.
  - From count=2, a dequeue raises oReady the next cycle; no accept is possible in that cycle.
  - From count=0, accept with no dequeue gives count=1.
  - Accept plus dequeue in the same cycle is impossible at count=0 because oValid=0.
- Full: iValid while oReady=0 is ignored; upstream must hold.
- Empty: oValid=0; the data outputs keep their last values (don't-care to the ALU).
- Pointer wrap: the 1-bit read and write pointers toggle on each dequeue and each legal enqueue respectively.
- No adder, subtractor or shift operators in RTL. The count update is a next-state case table over {enq, deq}.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, iAluReady=1 -> next cycle oValid=1, A=5, B=7, funct3=000, funct7=0000000, rd=3.
- ADDI x1,x0,-1 (0xFFF00093) -> B=0xFFFFFFFF, funct7=0000000. SRAI x1,x1,4 (0x4040D093) -> B=4, funct7=0100000.
- Hold iAluReady=0 and send 3 back-to-back legal instructions -> oCount reaches 2, oReady=0 on the third; then release -> the third is accepted only after the first dequeue, order preserved and head outputs stable while stalled.
- Load opcode 0x00002003, then OP with funct7=0000001 -> no enqueue, oIllegal pulses one cycle each, oCount unchanged.
- Count=1 with simultaneous accept and dequeue for 10 cycles -> oCount stays 1, oReady stays 1, every instruction emerges in order.
- Assert iRst mid-stall with count=2 -> asynchronously oValid=0, oCount=0, oReady=1; the first post-reset instruction emerges correctly.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes OP / OP-IMM instructions into ALU operands and buffers
// up to two decoded entries in a skid FIFO with a registered upstream ready.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iValid,
  output logic            oReady,
  input  logic [31:0]     iInstr,
  input  logic [XLEN-1:0] iRs1Data,
  input  logic [XLEN-1:0] iRs2Data,
  output logic            oValid,
  input  logic            iAluReady,
  output logic [XLEN-1:0] oDataA,
  output logic [XLEN-1:0] oDataB,
  output logic [2:0]      oFunct3,
  output logic [6:0]      oFunct7,
  output logic [4:0]      oRd,
  output logic            oIllegal,
  output logic [1:0]      oCount
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
  } entry_t;

  entry_t     dec;
  logic       legal;
  logic       accept, enq, deq;

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       ready_q, ready_d;
  logic       illegal_q, illegal_d;
  entry_t     head_q, head_d;
  entry_t     mem_q [DEPTH];
  entry_t     mem_d [DEPTH];

  // Decode at accept time so the buffer only ever holds ALU-ready fields.
  always_comb begin
    dec    = '0;
    dec.a  = iRs1Data;
    dec.f3 = iInstr[14:12];
    dec.rd = iInstr[11:7];
    legal  = 1'b0;
    case (iInstr[6:0])
      OPC_OP: begin
        dec.b  = iRs2Data;
        dec.f7 = iInstr[31:25];
        case (iInstr[31:25])
          F7_ZERO: legal = 1'b1;
          F7_ALT:  legal = (iInstr[14:12] == 3'b000) || (iInstr[14:12] == 3'b101);
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        if (iInstr[14:12] == 3'b001) begin
          dec.b  = {{(XLEN-5){1'b0}}, iInstr[24:20]};
          dec.f7 = iInstr[31:25];
          legal  = (iInstr[31:25] == F7_ZERO);
        end else if (iInstr[14:12] == 3'b101) begin
          dec.b  = {{(XLEN-5){1'b0}}, iInstr[24:20]};
          dec.f7 = iInstr[31:25];
          legal  = (iInstr[31:25] == F7_ZERO) || (iInstr[31:25] == F7_ALT);
        end else begin
          // funct7 forced to zero so ADDI can never select SUB.
          dec.b  = {{(XLEN-12){iInstr[31]}}, iInstr[31:20]};
          dec.f7 = F7_ZERO;
          legal  = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  assign accept = iValid & ready_q;
  assign enq    = accept & legal;
  assign deq    = oValid & iAluReady;

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10: begin
        case (count_q)
          2'd0:    count_d = 2'd1;
          2'd1:    count_d = 2'd2;
          default: count_d = count_q;
        endcase
      end
      2'b01: begin
        case (count_q)
          2'd1:    count_d = 2'd0;
          2'd2:    count_d = 2'd1;
          default: count_d = count_q;
        endcase
      end
      default: count_d = count_q;
    endcase

    wr_ptr_d  = wr_ptr_q ^ enq;
    rd_ptr_d  = rd_ptr_q ^ deq;
    ready_d   = (count_d != 2'd2);
    illegal_d = accept & ~legal;

    mem_d = mem_q;
    if (enq) mem_d[wr_ptr_q] = dec;

    // Head register tracks the next-cycle head; when empty it holds its last value.
    head_d = head_q;
    if (count_d != 2'd0) begin
      if (enq && (wr_ptr_q == rd_ptr_d)) head_d = dec;
      else                               head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      ready_q   <= 1'b1;
      illegal_q <= 1'b0;
      head_q    <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ready_q   <= ready_d;
      illegal_q <= illegal_d;
      head_q    <= head_d;
    end
  end

  // NOTE: the storage array is not reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge iClk) begin
    mem_q <= mem_d;
  end

  assign oReady   = ready_q;
  assign oValid   = (count_q != 2'd0);
  assign oCount   = count_q;
  assign oIllegal = illegal_q;
  assign oDataA   = head_q.a;
  assign oDataB   = head_q.b;
  assign oFunct3  = head_q.f3;
  assign oFunct7  = head_q.f7;
  assign oRd      = head_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_alu_issue_stage;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [31:0] iInstr;
  logic [31:0] iRs1Data;
  logic [31:0] iRs2Data;
  logic        oValid;
  logic        iAluReady;
  logic [31:0] oDataA;
  logic [31:0] oDataB;
  logic [2:0]  oFunct3;
  logic [6:0]  oFunct7;
  logic [4:0]  oRd;
  logic        oIllegal;
  logic [1:0]  oCount;

  alu_issue_stage dut (
    .iClk(iClk), .iRst(iRst),
    .iValid(iValid), .oReady(oReady),
    .iInstr(iInstr), .iRs1Data(iRs1Data), .iRs2Data(iRs2Data),
    .oValid(oValid), .iAluReady(iAluReady),
    .oDataA(oDataA), .oDataB(oDataB),
    .oFunct3(oFunct3), .oFunct7(oFunct7), .oRd(oRd),
    .oIllegal(oIllegal), .oCount(oCount)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  bit   m_ready = 1'b1;
  bit   m_ill   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Architectural rules written as plain field tests.
  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] rs1,
                                     input logic [31:0] rs2, output exp_t e, output bit ok);
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] top = ins[31:25];
    e.a = rs1; e.f3 = f3; e.rd = ins[11:7]; e.b = 0; e.f7 = 0; ok = 0;
    if (opc == 7'h33) begin
      e.b = rs2; e.f7 = top;
      ok = (top == 0) || (top == 7'h20 && (f3 == 0 || f3 == 5));
    end else if (opc == 7'h13) begin
      if (f3 == 1 || f3 == 5) begin
        e.b = 32'(ins[24:20]); e.f7 = top;
        ok = (top == 0) || (f3 == 5 && top == 7'h20);
      end else begin
        e.b = 32'($signed(ins[31:20])); e.f7 = 0; ok = 1;
      end
    end
  endfunction

  task automatic compare();
    check("valid", 32'(oValid), 32'(q.size() > 0));
    check("count", 32'(oCount), 32'(q.size()));
    check("ready", 32'(oReady), 32'(m_ready));
    check("illegal", 32'(oIllegal), 32'(m_ill));
    if (q.size() > 0) begin
      check("dataA", oDataA, q[0].a);
      check("dataB", oDataB, q[0].b);
      check("funct3", 32'(oFunct3), 32'(q[0].f3));
      check("funct7", 32'(oFunct7), 32'(q[0].f7));
      check("rd", 32'(oRd), 32'(q[0].rd));
    end
  endtask

  // One clock: check state at negedge, drive inputs, advance model, cross posedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic ar, output bit accepted);
    exp_t e;
    bit   ok, acc, dq;
    @(negedge iClk);
    compare();
    iValid = v; iInstr = ins; iRs1Data = r1; iRs2Data = r2; iAluReady = ar;
    ref_decode(ins, r1, r2, e, ok);
    acc = v && m_ready;
    dq  = (q.size() > 0) && ar;
    if (dq) void'(q.pop_front());
    if (acc && ok) q.push_back(e);
    m_ill   = acc && !ok;
    m_ready = (q.size() < 2);
    accepted = acc;
    @(posedge iClk);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                      input logic ar);
    bit acc = 0;
    for (int i = 0; i < 8 && !acc; i++) cycle(1'b1, ins, r1, r2, ar, acc);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input logic ar, input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, $urandom, ar, acc);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] top;
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 3))
      0: top = 7'h00;
      1: top = 7'h20;
      default: top = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0, 4:    return {top, w[24:7], 7'h33};
      1, 2:    return {top, w[24:7], 7'h13};
      default: return w;
    endcase
  endfunction

  initial begin
    bit acc;
    iRst = 1'b1; iValid = 1'b0; iInstr = '0; iRs1Data = '0; iRs2Data = '0; iAluReady = 1'b0;
    #12;
    compare();
    check("reset_dataA", oDataA, 32'd0);
    check("reset_dataB", oDataB, 32'd0);
    check("reset_funct7", 32'(oFunct7), 32'd0);
    iRst = 1'b0;

    // ADD x3,x1,x2 with explicit expected fields, then ADDI and SRAI.
    cycle(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, acc);
    @(negedge iClk);
    check("add_valid", 32'(oValid), 32'd1);
    check("add_A", oDataA, 32'd5);
    check("add_B", oDataB, 32'd7);
    check("add_f3", 32'(oFunct3), 32'd0);
    check("add_f7", 32'(oFunct7), 32'd0);
    check("add_rd", 32'(oRd), 32'd3);
    cycle(1'b1, 32'hFFF00093, 32'd0, 32'd9, 1'b1, acc);
    @(negedge iClk);
    check("addi_B", oDataB, 32'hFFFF_FFFF);
    check("addi_f7", 32'(oFunct7), 32'd0);
    cycle(1'b1, 32'h4040D093, 32'hF0, 32'd9, 1'b1, acc);
    @(negedge iClk);
    check("srai_B", oDataB, 32'd4);
    check("srai_f7", 32'(oFunct7), 32'h20);
    idle(1'b1, 2);

    // Stall: three back-to-back, third held until a slot frees.
    cycle(1'b1, 32'h00308233, 32'd11, 32'd12, 1'b0, acc);
    cycle(1'b1, 32'h404182B3, 32'd21, 32'd22, 1'b0, acc);
    cycle(1'b1, 32'h00520333, 32'd31, 32'd32, 1'b0, acc);
    cycle(1'b1, 32'h00520333, 32'd31, 32'd32, 1'b0, acc);
    cycle(1'b1, 32'h00520333, 32'd31, 32'd32, 1'b1, acc);
    send(32'h00520333, 32'd31, 32'd32, 1'b1);
    idle(1'b1, 3);

    // Illegal: load opcode, then OP with funct7=0000001, surrounding a held entry.
    cycle(1'b1, 32'h00108133, 32'd1, 32'd2, 1'b0, acc);
    cycle(1'b1, 32'h00002003, 32'd3, 32'd4, 1'b0, acc);
    cycle(1'b1, 32'h022081B3, 32'd5, 32'd6, 1'b0, acc);
    idle(1'b1, 3);

    // Sustained accept+dequeue at count 1.
    cycle(1'b1, 32'h00A00513, 32'd0, 32'd0, 1'b0, acc);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, {7'h00, 5'(i), 5'd1, 3'b000, 5'(i + 1), 7'h33}, 32'(i * 3), 32'(i), 1'b1, acc);
    idle(1'b1, 3);

    // Async reset mid-stall with two entries held.
    cycle(1'b1, 32'h00208033, 32'd7, 32'd8, 1'b0, acc);
    cycle(1'b1, 32'h00308033, 32'd9, 32'd10, 1'b0, acc);
    @(negedge iClk);
    compare();
    #2 iRst = 1'b1; iValid = 1'b0;
    #1;
    check("arst_valid", 32'(oValid), 32'd0);
    check("arst_count", 32'(oCount), 32'd0);
    check("arst_ready", 32'(oReady), 32'd1);
    q.delete(); m_ready = 1'b1; m_ill = 1'b0;
    @(posedge iClk);
    #3 iRst = 1'b0;
    cycle(1'b1, 32'h002081B3, 32'd55, 32'd66, 1'b1, acc);
    idle(1'b1, 2);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), acc);
    idle(1'b1, 3);
    @(negedge iClk);
    compare();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
